// File: rtl/mvm_stream.sv
// mvm_stream: streamed signed matrix-vector multiply y = A*x with one pipelined MAC per cycle
module mvm_stream #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int IN_W = 8,
  parameter int OUT_W = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    load_mat,
  input  logic                    relu_en,
  input  logic signed [IN_W-1:0]  s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic signed [OUT_W-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    done
);
  localparam int N = ROWS * COLS;
  localparam int ACC_W = 2 * IN_W + $clog2(COLS);
  localparam int PW = ACC_W > OUT_W ? ACC_W : OUT_W;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int KW = $clog2(N + 2);
  localparam logic [2:0] IDLE = 3'd0, LOAD_A = 3'd1, LOAD_X = 3'd2, COMPUTE = 3'd3, OUTPUT = 3'd4;
  localparam logic signed [PW-1:0] MAXV = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = ~MAXV;

  logic [2:0] state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q, r1_q, r2_q;
  logic [KW-1:0] cnt_q;
  logic mat_valid_q, relu_q, done_q;
  logic v1_q, v2_q, first1_q, first2_q, last1_q, last2_q;
  logic signed [IN_W-1:0] a_mem [N];
  logic signed [IN_W-1:0] x_mem [COLS];
  logic signed [OUT_W-1:0] y_mem [ROWS];
  logic signed [IN_W-1:0] a_q, x_q;
  logic signed [2*IN_W-1:0] prod_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, prod_ext;
  logic signed [PW-1:0] acc_x, ext, sat;
  logic signed [OUT_W-1:0] y_d;
  logic s_fire, m_fire, last_a, last_c, last_r, issue;

  assign s_ready = state_q == LOAD_A || state_q == LOAD_X;
  assign m_valid = state_q == OUTPUT;
  assign m_data = m_valid ? y_mem[row_q] : '0;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;
  assign last_a = idx_q == IW'(N - 1);
  assign last_c = col_q == CW'(COLS - 1);
  assign last_r = row_q == RW'(ROWS - 1);
  assign issue = state_q == COMPUTE && cnt_q < KW'(N);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (load_mat || !mat_valid_q) ? LOAD_A : LOAD_X;
      LOAD_A:  if (s_fire && last_a) state_d = LOAD_X;
      LOAD_X:  if (s_fire && last_c) state_d = COMPUTE;
      COMPUTE: if (cnt_q == KW'(N + 1)) state_d = OUTPUT;
      OUTPUT:  if (m_fire && last_r) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      col_q <= '0;
      row_q <= '0;
      cnt_q <= '0;
      mat_valid_q <= 1'b0;
      relu_q <= 1'b0;
      done_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= m_fire && last_r;
      v1_q <= issue;
      v2_q <= v1_q;
      if (state_q == IDLE && start) begin
        relu_q <= relu_en;
        if (load_mat) mat_valid_q <= 1'b0;
      end
      if (state_q == LOAD_A && s_fire && last_a) mat_valid_q <= 1'b1;
      if ((state_q == LOAD_A && s_fire) || issue) idx_q <= last_a ? '0 : idx_q + 1'b1;
      if ((state_q == LOAD_X && s_fire) || issue) col_q <= last_c ? '0 : col_q + 1'b1;
      if ((issue && last_c) || m_fire) row_q <= last_r ? '0 : row_q + 1'b1;
      if (state_q == COMPUTE) cnt_q <= state_d == OUTPUT ? '0 : cnt_q + 1'b1;
    end
  end

  // ReLU is applied to the full-width sum before any clamping or truncation
  always_comb begin
    prod_ext = prod_q;
    acc_d = first2_q ? prod_ext : acc_q + prod_ext;
    acc_x = acc_d;
    ext = (relu_q && acc_d[ACC_W-1]) ? '0 : acc_x;
    sat = ext > MAXV ? MAXV : (ext < MINV ? MINV : ext);
    y_d = SATURATE ? sat[OUT_W-1:0] : ext[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (state_q == LOAD_A && s_fire) a_mem[idx_q] <= s_data;
    if (state_q == LOAD_X && s_fire) x_mem[col_q] <= s_data;
    a_q <= a_mem[idx_q];
    x_q <= x_mem[col_q];
    first1_q <= col_q == '0;
    last1_q <= last_c;
    r1_q <= row_q;
    prod_q <= a_q * x_q;
    first2_q <= first1_q;
    last2_q <= last1_q;
    r2_q <= r1_q;
    if (v2_q) begin
      acc_q <= acc_d;
      if (last2_q) y_mem[r2_q] <= y_d;
    end
  end
endmodule

// File: tb/tb_mvm_stream.sv
// tb_mvm_stream: directed vector table plus reset, backpressure and 3x5 reference-model sequences
module tb_mvm_stream;
  logic clk = 1'b0, reset = 1'b1;
  logic start4 = 1'b0, start35 = 1'b0, load_mat = 1'b0, relu_en = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic signed [7:0] s_data = '0;
  logic rdy4, rdyw, rdy35, mv4, mvw, mv35, busy4, busyw, busy35, done4, donew, done35;
  logic signed [15:0] md4, mdw, md35;

  always #5 clk = ~clk;

  mvm_stream dut (.clk(clk), .reset(reset), .start(start4), .load_mat(load_mat), .relu_en(relu_en),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy4), .m_data(md4), .m_valid(mv4), .m_ready(m_ready),
    .busy(busy4), .done(done4));
  mvm_stream #(.SATURATE(1'b0)) dutw (.clk(clk), .reset(reset), .start(start4), .load_mat(load_mat),
    .relu_en(relu_en), .s_data(s_data), .s_valid(s_valid), .s_ready(rdyw), .m_data(mdw), .m_valid(mvw),
    .m_ready(m_ready), .busy(busyw), .done(donew));
  mvm_stream #(.ROWS(3), .COLS(5)) dut35 (.clk(clk), .reset(reset), .start(start35), .load_mat(load_mat),
    .relu_en(relu_en), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy35), .m_data(md35), .m_valid(mv35),
    .m_ready(m_ready), .busy(busy35), .done(done35));

  typedef struct {
    int load, relu, mat, mode;
    int x[4];
    int ys[4];
    int yw[4];
  } vec_t;

  int checks = 0, errors = 0;
  int exp_s[4], exp_w[4];
  int mix[16] = '{1, 2, 3, 4, -1, 0, 1, 0, 2, -3, 0, 5, 10, 10, 10, 10};
  vec_t tv[10];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int aval(input int mat, input int r, input int c);
    case (mat)
      0: return r == c ? 1 : 0;
      1: return 127;
      2: return -128;
      3: return r == c ? -1 : 0;
      default: return mix[r*4+c];
    endcase
  endfunction

  task automatic send(input int sel, input int val, input bit gaps);
    int n;
    bit fired;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      s_valid = 1'b0;
      s_data = 8'sh55;
      @(posedge clk); #1;
    end
    s_data = val[7:0];
    s_valid = 1'b1;
    n = 0;
    fired = 1'b0;
    while (!fired && n < 50) begin
      fired = sel != 0 ? rdy35 : rdy4;
      @(posedge clk); #1;
      n++;
    end
    s_valid = 1'b0;
    if (!fired) chk("send_accept", 0, 1);
  endtask

  task automatic collect(input int sel, input int n, input int mode);
    int got, cyc, stall;
    logic signed [15:0] d;
    logic v;
    got = 0;
    cyc = 0;
    stall = 0;
    v = 1'b0;
    while (got < n && cyc < 300) begin
      v = sel != 0 ? mv35 : mv4;
      d = sel != 0 ? md35 : md4;
      m_ready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && got == 2 && v && stall < 3) begin
        m_ready = 1'b0;
        stall++;
        chk("hold_stable", d, exp_s[2]);
      end
      if (v && m_ready) begin
        chk($sformatf("y%0d", got), d, exp_s[got]);
        if (sel == 0) chk($sformatf("yw%0d", got), mdw, exp_w[got]);
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b0;
    chk("out_count", got, n);
    chk("done_pulse", sel != 0 ? done35 : done4, 1);
    chk("m_valid_low", sel != 0 ? mv35 : mv4, 0);
    @(posedge clk); #1;
    chk("done_clear", sel != 0 ? done35 : done4, 0);
    chk("busy_idle", sel != 0 ? busy35 : busy4, 0);
  endtask

  task automatic run4(input vec_t v, input bit force_a);
    load_mat = v.load[0];
    relu_en = v.relu[0];
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    load_mat = 1'b0;
    relu_en = 1'b0;
    chk("busy_run", busy4, 1);
    if (v.load != 0 || force_a) for (int i = 0; i < 16; i++) send(0, aval(v.mat, i / 4, i % 4), v.mode == 1);
    for (int i = 0; i < 4; i++) send(0, v.x[i], v.mode == 1);
    chk("s_ready_after_x", rdy4, 0);
    for (int i = 0; i < 4; i++) begin
      exp_s[i] = v.ys[i];
      exp_w[i] = v.yw[i];
    end
    collect(0, 4, v.mode);
  endtask

  task automatic run35(input bit load, input int a[15]);
    int x[5];
    int acc;
    for (int i = 0; i < 5; i++) x[i] = int'($urandom_range(0, 255)) - 128;
    load_mat = load;
    start35 = 1'b1;
    @(posedge clk); #1;
    start35 = 1'b0;
    load_mat = 1'b0;
    if (load) for (int i = 0; i < 15; i++) send(1, a[i], 1'b1);
    for (int i = 0; i < 5; i++) send(1, x[i], 1'b1);
    chk("s_ready35_after_x", rdy35, 0);
    for (int r = 0; r < 3; r++) begin
      acc = 0;
      for (int c = 0; c < 5; c++) acc += a[r*5+c] * x[c];
      exp_s[r] = acc > 32767 ? 32767 : (acc < -32768 ? -32768 : acc);
    end
    collect(1, 3, 1);
  endtask

  initial begin
    int a35[15];
    tv[0] = '{1, 0, 0, 0, '{1, 2, 3, 4}, '{1, 2, 3, 4}, '{1, 2, 3, 4}};
    tv[1] = '{0, 0, 0, 0, '{5, 6, 7, 8}, '{5, 6, 7, 8}, '{5, 6, 7, 8}};
    tv[2] = '{1, 0, 1, 0, '{127, 127, 127, 127}, '{32767, 32767, 32767, 32767}, '{-1020, -1020, -1020, -1020}};
    tv[3] = '{1, 0, 2, 0, '{-128, -128, -128, -128}, '{32767, 32767, 32767, 32767}, '{0, 0, 0, 0}};
    tv[4] = '{0, 0, 2, 0, '{127, 127, 127, 127}, '{-32768, -32768, -32768, -32768}, '{512, 512, 512, 512}};
    tv[5] = '{1, 1, 3, 0, '{1, 2, 3, 4}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    tv[6] = '{0, 0, 3, 0, '{1, 2, 3, 4}, '{-1, -2, -3, -4}, '{-1, -2, -3, -4}};
    tv[7] = '{1, 0, 4, 0, '{3, -2, 1, 4}, '{18, -2, 32, 60}, '{18, -2, 32, 60}};
    tv[8] = '{1, 0, 4, 1, '{3, -2, 1, 4}, '{18, -2, 32, 60}, '{18, -2, 32, 60}};
    tv[9] = '{0, 1, 4, 2, '{3, -2, 1, 4}, '{18, 0, 32, 60}, '{18, 0, 32, 60}};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_s_ready", rdy4, 0);
    chk("rst_m_valid", mv4, 0);
    chk("rst_m_data", md4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    for (int i = 0; i < 10; i++) run4(tv[i], 1'b0);
    load_mat = 1'b1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    load_mat = 1'b0;
    for (int i = 0; i < 7; i++) send(0, aval(0, i / 4, i % 4), 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_s_ready", rdy4, 0);
    chk("midrst_m_valid", mv4, 0);
    chk("midrst_m_data", md4, 0);
    chk("midrst_busy", busy4, 0);
    chk("midrst_done", done4, 0);
    run4('{0, 0, 0, 0, '{2, 4, 6, 8}, '{2, 4, 6, 8}, '{2, 4, 6, 8}}, 1'b1);
    for (int i = 0; i < 15; i++) a35[i] = int'($urandom_range(0, 255)) - 128;
    run35(1'b1, a35);
    run35(1'b0, a35);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
